// File: rtl/vc_credit_flow_ctrl_if.sv
// rtl/vc_credit_flow_ctrl_if.sv - flit valid/ready bundle carrying payload and VC tag
interface vc_credit_flow_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int VC_W       = 1
);
    logic [DATA_WIDTH-1:0] data;
    logic [VC_W-1:0]       vc;
    logic                  valid;
    logic                  ready;

    modport master (output data, output vc, output valid, input ready);
    modport slave  (input data, input vc, input valid, output ready);
endinterface

// File: rtl/vc_credit_flow_ctrl.sv
// rtl/vc_credit_flow_ctrl.sv - per-VC credit flow control with a 1-deep registered output stage
module vc_credit_flow_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_VC       = 2,
    parameter int MAX_CREDITS  = 8,
    parameter int INIT_CREDITS = MAX_CREDITS,
    parameter int VC_W         = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    parameter int CRD_W        = $clog2(MAX_CREDITS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    vc_credit_flow_ctrl_if.slave      in_i,
    vc_credit_flow_ctrl_if.master     out_o,
    input  logic [NUM_VC-1:0]         credit_ret_i,
    output logic [NUM_VC*CRD_W-1:0]   credit_cnt_o,
    output logic                      credit_err_o
);

    localparam logic [VC_W:0]    NUM_VC_L = (VC_W + 1)'(NUM_VC);
    localparam logic [CRD_W-1:0] MAX_L    = CRD_W'(MAX_CREDITS);
    localparam logic [CRD_W-1:0] INIT_L   = CRD_W'(INIT_CREDITS);
    localparam logic [CRD_W-1:0] ONE_L    = CRD_W'(1);

    logic [CRD_W-1:0]      credit_q [NUM_VC];
    logic [CRD_W-1:0]      credit_d [NUM_VC];
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [VC_W-1:0]       vc_q, vc_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    logic                  vc_ok;
    logic                  vc_has_credit;
    logic                  in_ready;
    logic                  accept;
    logic [NUM_VC-1:0]     consume;

    // Accept gating: output slot free (or draining now) and the tagged VC owns a credit
    always_comb begin
        vc_ok         = ({1'b0, in_i.vc} < NUM_VC_L);
        vc_has_credit = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (in_i.vc == VC_W'(v) && credit_q[v] != '0) begin
                vc_has_credit = 1'b1;
            end
        end
        in_ready   = (!valid_q || out_o.ready) && vc_ok && vc_has_credit;
        in_i.ready = in_ready;
        accept     = in_i.valid && in_ready;
    end

    // Per-VC credit next state; a return at a full counter is dropped and flagged
    always_comb begin
        err_d = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            consume[v]  = accept && (in_i.vc == VC_W'(v));
            credit_d[v] = credit_q[v];
            if (credit_ret_i[v] && !consume[v]) begin
                if (credit_q[v] == MAX_L) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + ONE_L;
                end
            end else if (consume[v] && !credit_ret_i[v]) begin
                credit_d[v] = credit_q[v] - ONE_L;
            end
        end
    end

    // Output stage: load on accept, clear on drain, otherwise hold
    always_comb begin
        data_d  = data_q;
        vc_d    = vc_q;
        valid_d = valid_q;
        if (accept) begin
            data_d  = in_i.data;
            vc_d    = in_i.vc;
            valid_d = 1'b1;
        end else if (out_o.ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers; reset discards any in-flight flit and reloads credits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            vc_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            for (int v = 0; v < NUM_VC; v++) begin
                credit_q[v] <= INIT_L;
            end
        end else begin
            data_q  <= data_d;
            vc_q    <= vc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            for (int v = 0; v < NUM_VC; v++) begin
                credit_q[v] <= credit_d[v];
            end
        end
    end

    // Drive outputs and flatten counters, VC0 in the LSBs
    always_comb begin
        out_o.data   = data_q;
        out_o.vc     = vc_q;
        out_o.valid  = valid_q;
        credit_err_o = err_q;
        credit_cnt_o = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            credit_cnt_o[v*CRD_W +: CRD_W] = credit_q[v];
        end
    end

endmodule

// File: tb/tb_vc_credit_flow_ctrl.sv
// tb/tb_vc_credit_flow_ctrl.sv - scoreboard bench for vc_credit_flow_ctrl
module tb_vc_credit_flow_ctrl;

    localparam int DW   = 32;
    localparam int NVC  = 2;
    localparam int MAXC = 8;
    localparam int VCW  = 1;
    localparam int CRDW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NVC-1:0]      credit_ret;
    logic [NVC*CRDW-1:0] credit_cnt;
    logic                credit_err;

    always #5 clk = ~clk;

    vc_credit_flow_ctrl_if #(.DATA_WIDTH(DW), .VC_W(VCW)) in_bus ();
    vc_credit_flow_ctrl_if #(.DATA_WIDTH(DW), .VC_W(VCW)) out_bus ();

    vc_credit_flow_ctrl #(
        .DATA_WIDTH  (DW),
        .NUM_VC      (NVC),
        .MAX_CREDITS (MAXC),
        .INIT_CREDITS(MAXC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_i        (in_bus),
        .out_o       (out_bus),
        .credit_ret_i(credit_ret),
        .credit_cnt_o(credit_cnt),
        .credit_err_o(credit_err)
    );

    typedef struct {
        logic [DW-1:0]  d;
        logic [VCW-1:0] vc;
    } flit_t;

    flit_t exp_q[$];
    int    cred[NVC];
    bit    err_exp;
    bit    in_reset = 1'b1;
    int    checks = 0;
    int    errors = 0;
    int    n_out = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NVC*CRDW-1:0] model_cnt();
        logic [NVC*CRDW-1:0] e = '0;
        for (int v = 0; v < NVC; v++) e[v*CRDW +: CRDW] = CRDW'(cred[v]);
        return e;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int v = 0; v < NVC; v++) cred[v] = MAXC;
        err_exp = 1'b0;
    endtask

    // One clock of stimulus; want_rdy >= 0 also pins in_ready to a fixed value
    task automatic cycle(input bit v, input int vc, input bit rdy, input logic [NVC-1:0] ret,
                         input int want_rdy = -1);
        logic [DW-1:0] d = $urandom;
        bit exp_rdy, acc, nerr;
        @(negedge clk);
        in_bus.valid  = v;
        in_bus.vc     = VCW'(vc);
        in_bus.data   = d;
        out_bus.ready = rdy;
        credit_ret    = ret;
        #1;
        exp_rdy = (exp_q.size() == 0 || rdy) && (vc < NVC) && (cred[vc] != 0);
        chk("in_ready", 64'(in_bus.ready), 64'(exp_rdy));
        if (want_rdy >= 0) chk("in_ready_fixed", 64'(in_bus.ready), 64'(want_rdy));
        chk("credit_cnt", 64'(credit_cnt), 64'(model_cnt()));
        chk("credit_err", 64'(credit_err), 64'(err_exp));
        acc = v && exp_rdy;
        #2;
        if (acc) exp_q.push_back('{d: d, vc: VCW'(vc)});
        nerr = 1'b0;
        for (int i = 0; i < NVC; i++) begin
            bit cons = acc && (vc == i);
            if (ret[i] && !cons && cred[i] == MAXC) nerr = 1'b1;
            else cred[i] = cred[i] - int'(cons) + int'(ret[i]);
        end
        err_exp = nerr;
    endtask

    // Monitor: output presence must match scoreboard occupancy; transfers pop the head
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!in_reset) begin
                chk("out_valid", 64'(out_bus.valid), 64'(exp_q.size() != 0));
                if (out_bus.valid && exp_q.size() != 0) begin
                    chk("out_data", 64'(out_bus.data), 64'(exp_q[0].d));
                    chk("out_vc", 64'(out_bus.vc), 64'(exp_q[0].vc));
                    if (out_bus.ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
        end
    end

    initial begin
        int n0;
        in_bus.valid = 1'b0; in_bus.vc = '0; in_bus.data = '0;
        out_bus.ready = 1'b0; credit_ret = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_cnt", 64'(credit_cnt), 64'h88);
        chk("rst_valid", 64'(out_bus.valid), 64'd0);
        chk("rst_err", 64'(credit_err), 64'd0);
        rst_n = 1'b1;
        in_reset = 1'b0;

        // 8 flits on VC0 at full rate, then VC0 blocked while VC1 still passes
        n0 = n_out;
        for (int i = 0; i < 8; i++) cycle(1, 0, 1, '0, 1);
        cycle(1, 0, 1, '0, 0);
        chk("t2_cnt", 64'(credit_cnt), 64'h80);
        chk("t2_outs", 64'(n_out - n0), 64'd8);
        cycle(1, 1, 1, '0, 1);

        // A single return re-opens VC0 for exactly one flit
        cycle(0, 0, 1, 2'b01);
        cycle(1, 0, 1, '0, 1);
        chk("t3_cnt", 64'(credit_cnt), 64'h71);
        cycle(1, 0, 1, '0, 0);

        // Backpressure: output held, in_ready low, then release passes and accepts
        cycle(1, 1, 0, '0, 1);
        for (int i = 0; i < 5; i++) cycle(1, i % 2, 0, '0, 0);
        cycle(1, 1, 1, '0, 1);

        // Consume and return on VC1 at cnt1=3 cancel out
        for (int i = 0; i < 10 && cred[1] > 3; i++) cycle(1, 1, 1, '0);
        chk("t5_cnt1_pre", 64'(cred[1]), 64'd3);
        cycle(1, 1, 1, 2'b10, 1);
        cycle(0, 0, 1, '0);
        chk("t5_cnt1", 64'(credit_cnt[7:4]), 64'd3);

        // Overflow on VC0: counter saturates and credit_err pulses one cycle
        for (int i = 0; i < 10 && cred[0] < MAXC; i++) cycle(0, 0, 1, 2'b01);
        cycle(0, 0, 1, 2'b01);
        cycle(0, 0, 1, '0);
        chk("t5_err_hi", 64'(credit_err), 64'd1);
        chk("t5_cnt0", 64'(credit_cnt[3:0]), 64'd8);
        cycle(0, 0, 1, '0);
        chk("t5_err_lo", 64'(credit_err), 64'd0);

        // Asynchronous reset with a flit held at the output
        cycle(1, 0, 0, '0);
        cycle(0, 0, 0, '0);
        @(negedge clk);
        in_reset = 1'b1;
        in_bus.valid = 1'b0;
        credit_ret = '0;
        chk("t6_pre_valid", 64'(out_bus.valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_valid", 64'(out_bus.valid), 64'd0);
        chk("t6_data", 64'(out_bus.data), 64'd0);
        chk("t6_cnt", 64'(credit_cnt), 64'h88);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        in_reset = 1'b0;
        cycle(0, 0, 1, '0);
        chk("t6_cnt_after", 64'(credit_cnt), 64'h88);

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            logic [NVC-1:0] r;
            for (int b = 0; b < NVC; b++) r[b] = ($urandom_range(0, 3) == 0);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, NVC - 1),
                  $urandom_range(0, 3) != 0, r);
        end

        // Drain
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, '0);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
